mem_lsq_unit: RTL
=================

Name: mem_lsq_unit

Overview:
- Parametrised load/store unit for the Tomasulo core; successor to the single-entry memory stage.
- Accepts up to DEPTH issued memory ops from the reservation stations and keeps them in a program-order queue.
- Computes effective addresses and performs one access at a time against an internal word RAM with fixed multi-cycle latency.
- Broadcasts load results on the CDB through a req/grant handshake. Stores retire silently.

Parameters:
- DATA_W, 32, data word width.
- ADDR_W, 32, effective-address width.
- TAG_W, 5, reservation-station tag width.
- DEPTH, 4, queue entries; power of 2, ≥2.
- MEM_LAT, 2, access cycles per op; ≥1.
- MEM_WORDS, 256, internal RAM words; power of 2.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- issue_valid  in  1  issue request.
- issue_op  in  1  1 = load, 0 = store.
- issue_base  in  ADDR_W  base operand (Qj value).
- issue_offset  in  ADDR_W  immediate offset (A).
- issue_wdata  in  DATA_W  store data; ignored for loads.
- issue_tag  in  TAG_W  producer tag for the load result.
- issue_ready  out  1  queue not full.
- cdb_req  out  1  load result pending broadcast.
- cdb_tag  out  TAG_W  tag of the pending result.
- cdb_data  out  DATA_W  load data.
- cdb_grant  in  1  CDB arbiter grant.
- busy  out  1  queue non-empty or an access is in flight.
- count  out  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Reset values:
  - Queue empty, count=0, head and tail pointers 0, FSM=IDLE.
  - Outputs: cdb_req=0, cdb_tag=0, cdb_data=0, busy=0, issue_ready=1.
  - RAM contents are not reset.
  - Reset mid-operation aborts any in-flight access, drops all entries, and leaves RAM unchanged. This includes an access in its last ACCESS cycle: the reset edge wins, so no store write occurs.
- Issue:
  - Accepted on a posedge with issue_valid & issue_ready.
  - The unit stores op, addr = (issue_base + issue_offset) mod 2^ADDR_W, wdata and tag at the tail.
  - issue_valid while full is ignored; no state change.
- issue_ready = (count < DEPTH), combinational from count.
- Word index = addr[$clog2(MEM_WORDS)+1 : 2]. Upper bits and addr[1:0] are ignored, so addresses wrap modulo MEM_WORDS words.
- FSM (IDLE, ACCESS, WAIT_CDB); a latency counter runs in ACCESS:
  - IDLE: if count>0, go to ACCESS with lat_cnt=MEM_LAT-1. An entry written at edge N starts ACCESS at edge N+1.
  - ACCESS: decrement lat_cnt each cycle. At lat_cnt==0 the next edge does one of two things:
    - Store: write wdata to RAM, pop the entry, go to IDLE.
    - Load: latch RAM[word] into cdb_data and the tag into cdb_tag, set cdb_req=1, go to WAIT_CDB.
  - WAIT_CDB: cdb_req, cdb_tag and cdb_data hold steady until cdb_grant is sampled high. On that edge: cdb_req=0, pop the entry, go to IDLE. cdb_grant is ignored when cdb_req=0.
- Throughput and latency:
  - IDLE costs one cycle between ops, so a store occupies MEM_LAT+1 cycles.
  - A load into an empty queue asserts cdb_req MEM_LAT+1 edges after the issue edge, assuming an immediate grant.
- Ordering:
  - Ops execute strictly in issue order.
  - A load after a store to the same word returns the stored data.
- Simultaneous issue and pop on the same edge: count is unchanged, both pointers advance, and this is legal when full.
- Pointers wrap modulo DEPTH.
- busy = (count != 0).

Test Plan:
1. Reset, then store addr base=0x10, offset=0x4 (word 5) data=0xDEADBEEF; after 3 cycles load base=0x14, offset=0, tag=7 → cdb_req rises 3 edges after the load issue edge with cdb_tag=7, cdb_data=0xDEADBEEF; grant → cdb_req=0 next edge, busy=0.
2. Back-to-back issue of DEPTH=4 stores while the unit stalls → issue_ready=0 after the 4th; a 5th issue is ignored and count stays 4; the queue drains with each store taking 3 cycles.
3. Load with cdb_grant held low for 10 cycles → cdb_req, cdb_tag and cdb_data stay stable throughout; a queued store behind it does not start until grant.
4. Address wrap: store base=0xFFFFFFFC, offset=0x8 → writes word 1; load addr 0x404 (word 1 mod 256) → returns the same data.
5. Issue and pop on the same edge while full → count stays 4 and no entry is lost or duplicated; checked by draining and comparing 4 load tags in order.
6. Assert rst during ACCESS of a store to word 9 (old value 0x1, new 0x2) → word 9 reads 0x1 afterwards; after reset count=0, cdb_req=0, issue_ready=1.

Source files
------------

// File: rtl/mem_lsq_unit.sv
// Load/store unit: program-order queue in front of a fixed-latency word RAM.
// Load results go out on the CDB through a req/grant handshake.
module mem_lsq_unit #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int TAG_W     = 5,
    parameter int DEPTH     = 4,
    parameter int MEM_LAT   = 2,
    parameter int MEM_WORDS = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       issue_valid,
    input  logic                       issue_op,
    input  logic [ADDR_W-1:0]          issue_base,
    input  logic [ADDR_W-1:0]          issue_offset,
    input  logic [DATA_W-1:0]          issue_wdata,
    input  logic [TAG_W-1:0]           issue_tag,
    output logic                       issue_ready,
    output logic                       cdb_req,
    output logic [TAG_W-1:0]           cdb_tag,
    output logic [DATA_W-1:0]          cdb_data,
    input  logic                       cdb_grant,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT_CDB} state_e;

    state_e              state_q, state_d;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic [PTR_W-1:0]    head_q, tail_q;
    logic [CNT_W-1:0]    count_q;
    logic                cdb_req_q, cdb_req_d;
    logic [TAG_W-1:0]    cdb_tag_q, cdb_tag_d;
    logic [DATA_W-1:0]   cdb_data_q, cdb_data_d;

    logic                op_q    [DEPTH];
    logic [IDX_W-1:0]    idx_q   [DEPTH];
    logic [DATA_W-1:0]   wdata_q [DEPTH];
    logic [TAG_W-1:0]    tag_q   [DEPTH];
    logic [DATA_W-1:0]   mem_q   [MEM_WORDS];

    logic [ADDR_W-1:0]   ea;
    logic                unused_ea;
    logic                push, pop, mem_we;

    assign ea        = issue_base + issue_offset;
    assign unused_ea = ^{ea[ADDR_W-1:IDX_W+2], ea[1:0]};

    assign issue_ready = (count_q < CNT_W'(DEPTH));
    // A full queue can still take an op on the edge its head retires.
    assign push        = issue_valid && (issue_ready || pop);
    assign busy        = (count_q != '0);
    assign count       = count_q;
    assign cdb_req     = cdb_req_q;
    assign cdb_tag     = cdb_tag_q;
    assign cdb_data    = cdb_data_q;

    always_comb begin
        state_d    = state_q;
        lat_d      = lat_q;
        pop        = 1'b0;
        mem_we     = 1'b0;
        cdb_req_d  = cdb_req_q;
        cdb_tag_d  = cdb_tag_q;
        cdb_data_d = cdb_data_q;
        unique case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    state_d = ACCESS;
                    lat_d   = LAT_W'(MEM_LAT - 1);
                end
            end
            ACCESS: begin
                if (lat_q != '0) begin
                    lat_d = lat_q - 1'b1;
                end else if (op_q[head_q]) begin
                    cdb_req_d  = 1'b1;
                    cdb_tag_d  = tag_q[head_q];
                    cdb_data_d = mem_q[idx_q[head_q]];
                    state_d    = WAIT_CDB;
                end else begin
                    mem_we  = !rst;
                    pop     = 1'b1;
                    state_d = IDLE;
                end
            end
            WAIT_CDB: begin
                if (cdb_grant) begin
                    cdb_req_d = 1'b0;
                    pop       = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            lat_q      <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            cdb_req_q  <= 1'b0;
            cdb_tag_q  <= '0;
            cdb_data_q <= '0;
        end else begin
            state_q    <= state_d;
            lat_q      <= lat_d;
            cdb_req_q  <= cdb_req_d;
            cdb_tag_q  <= cdb_tag_d;
            cdb_data_q <= cdb_data_d;
            if (push) tail_q <= tail_q + 1'b1;
            if (pop)  head_q <= head_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            op_q[tail_q]    <= issue_op;
            idx_q[tail_q]   <= ea[IDX_W+1:2];
            wdata_q[tail_q] <= issue_wdata;
            tag_q[tail_q]   <= issue_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[idx_q[head_q]] <= wdata_q[head_q];
    end

endmodule
